// File: rtl/chip_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states, transaction owner, counter width.
package chip_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts data grants issued while fetch is waiting; saturates at MAX_DATA_BURST.
// sat_o is registered state, so it affects arbitration from the cycle after the count is reached.
module arb_starve_cnt
  import chip_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic                    if_gnt_i,
  input  logic                    dm_gnt_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    sat_o
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX_DATA_BURST);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt_i || !if_req_i) begin
      cnt_d = '0;
    end else if (dm_gnt_i && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-outstanding memory port.
// Grant is combinational in IDLE; mem_req_o follows one cycle later; rvalid pulses the cycle after mem_ready_i.
module mem_arbiter
  import chip_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic                    starve_sat;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  arb_starve_cnt #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_starve_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (if_req_i),
    .if_gnt_i (if_gnt_o),
    .dm_gnt_i (dm_gnt_o),
    .cnt_o    (starve_cnt),
    .sat_o    (starve_sat)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins unless fetch has already waited out a full burst.
        if (!rst_i) begin
          if (dm_req_i && !(starve_sat && if_req_i)) begin
            dm_gnt_o = 1'b1;
          end else if (if_req_i) begin
            if_gnt_o = 1'b1;
          end
        end
        if (dm_gnt_o) begin
          state_d     = BUSY_DM;
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          mem_be_d    = dm_be_i;
        end else if (if_gnt_o) begin
          state_d     = BUSY_IF;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end else begin
            dm_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule
